// File: rtl/dutif_pwrseq.sv
// Power/reset sequencer: ramps the vdd/vdd1/vdd2 PDM setpoints over a write-only Wishbone master
// and sequences DUT reset. Optional bus timeout with sticky error state: `PWRSEQ_TIMEOUT_EN.
module dutif_pwrseq #(
   parameter logic [9:0]  STEP  = 10'd16,
   parameter int unsigned DLY_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_up,
   input  logic             cmd_down,
   input  logic [9:0]       cfg_tgt_vdd,
   input  logic [9:0]       cfg_tgt_vdd1,
   input  logic [9:0]       cfg_tgt_vdd2,
   input  logic [DLY_W-1:0] cfg_step_dly,
   input  logic [DLY_W-1:0] cfg_settle,
   input  logic [7:0]       cfg_crg,
   output logic [3:0]       wb_addr,
   output logic [31:0]      wb_wdata,
   output logic             wb_we,
   output logic             wb_cyc,
   input  logic             wb_ack,
   output logic             busy,
   output logic             pwr_on,
   output logic             err
);
   localparam int unsigned RAIL_W   = 10;
   localparam logic [3:0]  ADDR_VDD = 4'd1;
   localparam logic [3:0]  ADDR_CRG = 4'd0;

   typedef enum logic [2:0] {
      S_OFF, S_RUP, S_SETL, S_REL, S_ON, S_ARST, S_RDN, S_ERR
   } state_e;

   state_e              state_q, state_d;
   logic                cyc_q, cyc_d;
   logic [3:0]          addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic [RAIL_W-1:0]   cur_vdd_q, cur_vdd_d, cur_vdd1_q, cur_vdd1_d, cur_vdd2_q, cur_vdd2_d;
   logic [RAIL_W-1:0]   tgt_vdd_q, tgt_vdd_d, tgt_vdd1_q, tgt_vdd1_d, tgt_vdd2_q, tgt_vdd2_d;
   logic [DLY_W-1:0]    cnt_q, cnt_d;
   logic                down_q, down_d;
   logic                busy_q, busy_d, pwr_on_q, pwr_on_d, err_q, err_d;
`ifdef PWRSEQ_TIMEOUT_EN
   logic [7:0]          to_q, to_d;
`endif
   logic [RAIL_W-1:0]   up_vdd_c, up_vdd1_c, up_vdd2_c, dn_vdd_c, dn_vdd1_c, dn_vdd2_c;
   logic                at_tgt_c, at_zero_c;
   logic [7:0]          crg_base_c;

   // Saturating ramp steps; the up step is done one bit wider so cur + STEP cannot wrap.
   function automatic logic [RAIL_W-1:0] step_up(input logic [RAIL_W-1:0] cur,
                                                 input logic [RAIL_W-1:0] tgt);
      logic [RAIL_W:0] sum;
      sum = {1'b0, cur} + {1'b0, STEP};
      return (sum > {1'b0, tgt}) ? tgt : sum[RAIL_W-1:0];
   endfunction

   function automatic logic [RAIL_W-1:0] step_dn(input logic [RAIL_W-1:0] cur);
      return (cur > STEP) ? (cur - STEP) : '0;
   endfunction

   assign up_vdd_c   = step_up(cur_vdd_q,  tgt_vdd_q);
   assign up_vdd1_c  = step_up(cur_vdd1_q, tgt_vdd1_q);
   assign up_vdd2_c  = step_up(cur_vdd2_q, tgt_vdd2_q);
   assign dn_vdd_c   = step_dn(cur_vdd_q);
   assign dn_vdd1_c  = step_dn(cur_vdd1_q);
   assign dn_vdd2_c  = step_dn(cur_vdd2_q);
   assign at_tgt_c   = (cur_vdd_q == tgt_vdd_q) && (cur_vdd1_q == tgt_vdd1_q) &&
                       (cur_vdd2_q == tgt_vdd2_q);
   assign at_zero_c  = (cur_vdd_q == '0) && (cur_vdd1_q == '0) && (cur_vdd2_q == '0);
   // Bits [3:2] carry rst_mode, so the configured value there is masked off.
   assign crg_base_c = cfg_crg & 8'hF3;

   // State register (with datapath registers)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= S_OFF;
         cyc_q      <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         cur_vdd_q  <= '0;
         cur_vdd1_q <= '0;
         cur_vdd2_q <= '0;
         tgt_vdd_q  <= '0;
         tgt_vdd1_q <= '0;
         tgt_vdd2_q <= '0;
         cnt_q      <= '0;
         down_q     <= 1'b0;
         busy_q     <= 1'b0;
         pwr_on_q   <= 1'b0;
         err_q      <= 1'b0;
`ifdef PWRSEQ_TIMEOUT_EN
         to_q       <= '0;
`endif
      end else begin
         state_q    <= state_d;
         cyc_q      <= cyc_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         cur_vdd_q  <= cur_vdd_d;
         cur_vdd1_q <= cur_vdd1_d;
         cur_vdd2_q <= cur_vdd2_d;
         tgt_vdd_q  <= tgt_vdd_d;
         tgt_vdd1_q <= tgt_vdd1_d;
         tgt_vdd2_q <= tgt_vdd2_d;
         cnt_q      <= cnt_d;
         down_q     <= down_d;
         busy_q     <= busy_d;
         pwr_on_q   <= pwr_on_d;
         err_q      <= err_d;
`ifdef PWRSEQ_TIMEOUT_EN
         to_q       <= to_d;
`endif
      end
   end

   // Next state: either finish the write in flight, or count down the idle gap and act.
   always_comb begin
      state_d    = state_q;
      cyc_d      = cyc_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      cur_vdd_d  = cur_vdd_q;
      cur_vdd1_d = cur_vdd1_q;
      cur_vdd2_d = cur_vdd2_q;
      tgt_vdd_d  = tgt_vdd_q;
      tgt_vdd1_d = tgt_vdd1_q;
      tgt_vdd2_d = tgt_vdd2_q;
      cnt_d      = cnt_q;
      down_d     = down_q;
`ifdef PWRSEQ_TIMEOUT_EN
      to_d       = to_q;
`endif
      if (cyc_q) begin
         if (cmd_down && (state_q == S_RUP || state_q == S_REL)) down_d = 1'b1;
         if (wb_ack) begin
            cyc_d = 1'b0;
`ifdef PWRSEQ_TIMEOUT_EN
            to_d  = '0;
`endif
            if (down_d) begin
               state_d = S_ARST;
               cnt_d   = '0;
               down_d  = 1'b0;
            end else begin
               case (state_q)
                  S_RUP: begin
                     if (at_tgt_c) begin
                        state_d = S_SETL;
                        cnt_d   = cfg_settle;
                     end else begin
                        cnt_d   = cfg_step_dly;
                     end
                  end
                  S_REL:  state_d = S_ON;
                  S_ARST: begin
                     state_d = S_RDN;
                     cnt_d   = '0;
                  end
                  S_RDN: begin
                     if (at_zero_c) state_d = S_OFF;
                     else           cnt_d   = cfg_step_dly;
                  end
                  default: ;
               endcase
            end
         end
`ifdef PWRSEQ_TIMEOUT_EN
         else if (to_q == 8'd254) begin
            cyc_d   = 1'b0;
            state_d = S_ERR;
            down_d  = 1'b0;
            to_d    = '0;
         end else begin
            to_d    = to_q + 8'd1;
         end
`endif
      end else begin
         case (state_q)
            S_OFF: begin
               if (cmd_up && !cmd_down) begin
                  state_d    = S_RUP;
                  tgt_vdd_d  = cfg_tgt_vdd;
                  tgt_vdd1_d = cfg_tgt_vdd1;
                  tgt_vdd2_d = cfg_tgt_vdd2;
                  cnt_d      = '0;
               end
            end
            S_RUP, S_SETL: begin
               if (cmd_down) begin
                  state_d = S_ARST;
                  cnt_d   = '0;
               end else if (cnt_q > DLY_W'(1)) begin
                  cnt_d   = cnt_q - DLY_W'(1);
               end else if (state_q == S_RUP) begin
                  cyc_d      = 1'b1;
                  addr_d     = ADDR_VDD;
                  cur_vdd_d  = up_vdd_c;
                  cur_vdd1_d = up_vdd1_c;
                  cur_vdd2_d = up_vdd2_c;
                  wdata_d    = {2'b00, up_vdd_c, up_vdd1_c, up_vdd2_c};
               end else begin
                  state_d = S_REL;
                  cyc_d   = 1'b1;
                  addr_d  = ADDR_CRG;
                  wdata_d = {24'd0, crg_base_c | 8'h04};
               end
            end
            S_ON: begin
               if (cmd_down) begin
                  state_d = S_ARST;
                  cnt_d   = '0;
               end
            end
            S_ARST: begin
               cyc_d   = 1'b1;
               addr_d  = ADDR_CRG;
               wdata_d = {24'd0, crg_base_c};
            end
            S_RDN: begin
               if (cnt_q > DLY_W'(1)) begin
                  cnt_d = cnt_q - DLY_W'(1);
               end else begin
                  cyc_d      = 1'b1;
                  addr_d     = ADDR_VDD;
                  cur_vdd_d  = dn_vdd_c;
                  cur_vdd1_d = dn_vdd1_c;
                  cur_vdd2_d = dn_vdd2_c;
                  wdata_d    = {2'b00, dn_vdd_c, dn_vdd1_c, dn_vdd2_c};
               end
            end
            default: ;
         endcase
      end
   end

   // Status outputs decoded from the next state so they are registered alongside it.
   always_comb begin
      busy_d   = (state_d != S_OFF) && (state_d != S_ON);
      pwr_on_d = (state_d == S_ON);
`ifdef PWRSEQ_TIMEOUT_EN
      err_d    = (state_d == S_ERR);
`else
      err_d    = 1'b0;
`endif
   end

   assign wb_cyc   = cyc_q;
   assign wb_we    = cyc_q;
   assign wb_addr  = addr_q;
   assign wb_wdata = wdata_q;
   assign busy     = busy_q;
   assign pwr_on   = pwr_on_q;
   assign err      = err_q;

endmodule
